// File: rtl/pwl_filter_reset_seq_pkg.sv
// rtl/pwl_filter_reset_seq_pkg.sv - sequencer state type and phase-ordering helper for pwl_filter_reset_seq
package pwl_rst_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SNAP   = 3'd1,
    HOLD   = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } seq_state_e;

  // Next phase after 'cur', skipping any phase whose latched count is zero.
  function automatic seq_state_e next_phase(input seq_state_e cur,
                                            input logic       snap_nz,
                                            input logic       hold_nz,
                                            input logic       settle_nz);
    seq_state_e nxt;
    nxt = IDLE;
    case (cur)
      IDLE:    nxt = snap_nz ? SNAP : (hold_nz ? HOLD : (settle_nz ? SETTLE : DONE));
      SNAP:    nxt = hold_nz ? HOLD : (settle_nz ? SETTLE : DONE);
      HOLD:    nxt = settle_nz ? SETTLE : DONE;
      SETTLE:  nxt = DONE;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/pwl_rst_phase_cnt.sv
// rtl/pwl_rst_phase_cnt.sv - loadable down-counter that flags the last cycle of a phase
module pwl_rst_phase_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Reload on phase entry, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A count of one means the current cycle is the final cycle of the phase.
  assign expire = (cnt_q == ONE);

endmodule

// File: rtl/pwl_filter_reset_seq.sv
// rtl/pwl_filter_reset_seq.sv - SNAP/HOLD/SETTLE reset sequencer for a PWL filter; PWL_RST_SEQ_STATS_EN adds seq/abort counters
module pwl_filter_reset_seq #(
  parameter int  CNT_W   = 8,
  parameter real FP_SNAP = 0.0,
  parameter real FP_HOLD = 1.0e9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             abort,
  input  logic [CNT_W-1:0] snap_cycles,
  input  logic [CNT_W-1:0] hold_cycles,
  input  logic [CNT_W-1:0] settle_cycles,
  output logic             ack,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             filt_reset,
  output real              fp_rst
`ifdef PWL_RST_SEQ_STATS_EN
  ,
  output logic [15:0]      seq_count,
  output logic [15:0]      abort_count
`endif
);

  import pwl_rst_seq_pkg::*;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] snap_len_q, snap_len_d;
  logic [CNT_W-1:0] hold_len_q, hold_len_d;
  logic [CNT_W-1:0] settle_len_q, settle_len_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             filt_reset_q, filt_reset_d;
  logic             fp_snap_q, fp_snap_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_expire;

  pwl_rst_phase_cnt #(
    .CNT_W (CNT_W)
  ) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .expire   (cnt_expire)
  );

  // Next state, count latching at acceptance and phase-counter reload on every phase entry.
  always_comb begin
    state_d      = state_q;
    snap_len_d   = snap_len_q;
    hold_len_d   = hold_len_q;
    settle_len_d = settle_len_q;
    ack_d        = 1'b0;
    aborted_d    = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;

    case (state_q)
      IDLE: begin
        // abort is deliberately not looked at here: a request always wins in IDLE.
        if (req) begin
          snap_len_d   = snap_cycles;
          hold_len_d   = hold_cycles;
          settle_len_d = settle_cycles;
          ack_d        = 1'b1;
          cnt_load     = 1'b1;
          state_d      = next_phase(IDLE, snap_cycles != '0, hold_cycles != '0,
                                    settle_cycles != '0);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        // Abort beats phase expiry, so an abort on the last SETTLE cycle yields no done.
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (cnt_expire) begin
          cnt_load = 1'b1;
          state_d  = next_phase(state_q, snap_len_q != '0, hold_len_q != '0,
                                settle_len_q != '0);
        end
      end
    endcase

    case (state_d)
      SNAP:    cnt_load_val = snap_len_d;
      HOLD:    cnt_load_val = hold_len_d;
      SETTLE:  cnt_load_val = settle_len_d;
      default: cnt_load_val = '0;
    endcase
  end

  // Output flops decode the state being entered so they line up with state_q.
  always_comb begin
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
    filt_reset_d = (state_d == SNAP) || (state_d == HOLD);
    fp_snap_d    = (state_d == SNAP);
  end

  // State, latched counts and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      snap_len_q   <= '0;
      hold_len_q   <= '0;
      settle_len_q <= '0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      filt_reset_q <= 1'b0;
      fp_snap_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_len_q   <= snap_len_d;
      hold_len_q   <= hold_len_d;
      settle_len_q <= settle_len_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      filt_reset_q <= filt_reset_d;
      fp_snap_q    <= fp_snap_d;
    end
  end

  assign ack        = ack_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign filt_reset = filt_reset_q;
  // The pole is a pure function of the registered SNAP flag, so it changes only on clock edges.
  assign fp_rst     = fp_snap_q ? FP_SNAP : FP_HOLD;

`ifdef PWL_RST_SEQ_STATS_EN
  logic [15:0] seq_count_q, seq_count_d;
  logic [15:0] abort_count_q, abort_count_d;

  // Saturating tallies that step together with the done/aborted pulses they count.
  always_comb begin
    seq_count_d   = seq_count_q;
    abort_count_d = abort_count_q;
    if (done_d && (seq_count_q != 16'hFFFF)) begin
      seq_count_d = seq_count_q + 16'd1;
    end
    if (aborted_d && (abort_count_q != 16'hFFFF)) begin
      abort_count_d = abort_count_q + 16'd1;
    end
  end

  // Tally registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_count_q   <= 16'd0;
      abort_count_q <= 16'd0;
    end else begin
      seq_count_q   <= seq_count_d;
      abort_count_q <= abort_count_d;
    end
  end

  assign seq_count   = seq_count_q;
  assign abort_count = abort_count_q;
`endif

endmodule

// File: tb/tb_pwl_filter_reset_seq.sv
// tb/tb_pwl_filter_reset_seq.sv - scoreboard bench for pwl_filter_reset_seq; PWL_RST_SEQ_STATS_EN enables counter checks
module tb_pwl_filter_reset_seq;

  localparam int  CNT_W     = 8;
  localparam real FP_SNAP_V = 0.0;
  localparam real FP_HOLD_V = 1.0e9;

  logic             clk = 1'b0;
  logic             reset;
  logic             req;
  logic             abort;
  logic [CNT_W-1:0] snap_cycles;
  logic [CNT_W-1:0] hold_cycles;
  logic [CNT_W-1:0] settle_cycles;
  logic             ack;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             filt_reset;
  real              fp_rst;
`ifdef PWL_RST_SEQ_STATS_EN
  logic [15:0]      seq_count;
  logic [15:0]      abort_count;
`endif

  int errors = 0;
  int checks = 0;
  int exp_done = 0;
  int exp_abort = 0;

  // Each entry: {ack, busy, done, aborted, filt_reset, fp_rst_is_snap}
  logic [5:0] exp_q[$];

  pwl_filter_reset_seq #(
    .CNT_W   (CNT_W),
    .FP_SNAP (FP_SNAP_V),
    .FP_HOLD (FP_HOLD_V)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .abort         (abort),
    .snap_cycles   (snap_cycles),
    .hold_cycles   (hold_cycles),
    .settle_cycles (settle_cycles),
    .ack           (ack),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .filt_reset    (filt_reset),
    .fp_rst        (fp_rst)
`ifdef PWL_RST_SEQ_STATS_EN
    ,
    .seq_count     (seq_count),
    .abort_count   (abort_count)
`endif
  );

  always #5 clk = ~clk;

  // Expected outputs k cycles after the accepting edge for counts (a,b,c): n = 1+a+b+c.
  function automatic logic [5:0] exp_at(input int k, input int a, input int b, input int c);
    int n;
    n = 1 + a + b + c;
    return {k == 1, k <= n, k == n, 1'b0, k <= a + b, k <= a};
  endfunction

  function automatic void push_seq(input int a, input int b, input int c);
    for (int k = 1; k <= 1 + a + b + c; k++) exp_q.push_back(exp_at(k, a, b, c));
  endfunction

  function automatic void push_idle(input int m);
    for (int i = 0; i < m; i++) exp_q.push_back(6'b000000);
  endfunction

  task automatic test_reset();
    reset = 1'b1; req = 1'b1; abort = 1'b0;
    snap_cycles = 8'd3; hold_cycles = 8'd3; settle_cycles = 8'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ack, busy, done, aborted, filt_reset} !== 5'b00000 || fp_rst != FP_HOLD_V) begin
      errors++;
      $display("FAIL reset_state: got %b fp=%g, want 00000 fp=%g",
               {ack, busy, done, aborted, filt_reset}, fp_rst, FP_HOLD_V);
    end
    req = 1'b0; reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sequence(input int a, input int b, input int c, input string name);
    logic [5:0] e;
    int k;
    push_seq(a, b, c);
    push_idle(2);
    exp_done++;
    snap_cycles = a[CNT_W-1:0]; hold_cycles = b[CNT_W-1:0]; settle_cycles = c[CNT_W-1:0];
    req = 1'b1;
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      k++;
      e = exp_q.pop_front();
      checks++;
      if ({ack, busy, done, aborted, filt_reset} !== e[5:1] ||
          fp_rst != (e[0] ? FP_SNAP_V : FP_HOLD_V)) begin
        errors++;
        $display("FAIL %s k=%0d: got %b fp=%g, want %b fp=%g", name, k,
                 {ack, busy, done, aborted, filt_reset}, fp_rst, e[5:1],
                 e[0] ? FP_SNAP_V : FP_HOLD_V);
      end
      if (k == 1) begin
        req = 1'b0;
        snap_cycles   = CNT_W'($urandom_range(1, 255));
        hold_cycles   = CNT_W'($urandom_range(1, 255));
        settle_cycles = CNT_W'($urandom_range(1, 255));
      end
    end
  endtask

  task automatic test_abort(input int a, input int b, input int c, input int abort_k,
                            input string name);
    logic [5:0] e;
    int k;
    for (int i = 1; i <= abort_k; i++) exp_q.push_back(exp_at(i, a, b, c));
    exp_q.push_back(6'b000100);
    push_idle(1);
    exp_abort++;
    snap_cycles = a[CNT_W-1:0]; hold_cycles = b[CNT_W-1:0]; settle_cycles = c[CNT_W-1:0];
    req = 1'b1;
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      k++;
      e = exp_q.pop_front();
      checks++;
      if ({ack, busy, done, aborted, filt_reset} !== e[5:1] ||
          fp_rst != (e[0] ? FP_SNAP_V : FP_HOLD_V)) begin
        errors++;
        $display("FAIL %s k=%0d: got %b fp=%g, want %b fp=%g", name, k,
                 {ack, busy, done, aborted, filt_reset}, fp_rst, e[5:1],
                 e[0] ? FP_SNAP_V : FP_HOLD_V);
      end
      if (k == 1) req = 1'b0;
      abort = (k == abort_k);
    end
    abort = 1'b0;
  endtask

  task automatic test_abort_ignored();
    logic [5:0] e;
    int k;
    // abort held through IDLE acceptance, DONE and the following IDLE cycle.
    push_seq(0, 0, 0);
    push_idle(2);
    push_seq(2, 0, 0);
    push_idle(1);
    exp_done += 2;
    snap_cycles = 8'd0; hold_cycles = 8'd0; settle_cycles = 8'd0;
    req = 1'b1; abort = 1'b1;
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      k++;
      e = exp_q.pop_front();
      checks++;
      if ({ack, busy, done, aborted, filt_reset} !== e[5:1] ||
          fp_rst != (e[0] ? FP_SNAP_V : FP_HOLD_V)) begin
        errors++;
        $display("FAIL abort_ignored k=%0d: got %b fp=%g, want %b fp=%g", k,
                 {ack, busy, done, aborted, filt_reset}, fp_rst, e[5:1],
                 e[0] ? FP_SNAP_V : FP_HOLD_V);
      end
      if (k == 1) req = 1'b0;
      if (k == 3) begin
        snap_cycles = 8'd2;
        req = 1'b1;
      end
      if (k == 4) begin
        req = 1'b0;
        abort = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] e;
    int j;
    // req held high: the second sequence starts from the IDLE cycle after DONE.
    push_seq(1, 0, 1);
    push_idle(1);
    push_seq(1, 0, 1);
    push_idle(2);
    exp_done += 2;
    snap_cycles = 8'd1; hold_cycles = 8'd0; settle_cycles = 8'd1;
    req = 1'b1;
    j = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      j++;
      e = exp_q.pop_front();
      checks++;
      if ({ack, busy, done, aborted, filt_reset} !== e[5:1] ||
          fp_rst != (e[0] ? FP_SNAP_V : FP_HOLD_V)) begin
        errors++;
        $display("FAIL back_to_back j=%0d: got %b fp=%g, want %b fp=%g", j,
                 {ack, busy, done, aborted, filt_reset}, fp_rst, e[5:1],
                 e[0] ? FP_SNAP_V : FP_HOLD_V);
      end
      if (j == 5) req = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] e;
    int j;
    // counts (1,1,5): SETTLE visible for k=3..7; reset sampled at the end of k=4.
    for (int k = 1; k <= 4; k++) exp_q.push_back(exp_at(k, 1, 1, 5));
    push_idle(1);
    push_seq(1, 1, 5);
    push_idle(2);
    snap_cycles = 8'd1; hold_cycles = 8'd1; settle_cycles = 8'd5;
    req = 1'b1;
    j = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      j++;
      e = exp_q.pop_front();
      checks++;
      if ({ack, busy, done, aborted, filt_reset} !== e[5:1] ||
          fp_rst != (e[0] ? FP_SNAP_V : FP_HOLD_V)) begin
        errors++;
        $display("FAIL reset_mid j=%0d: got %b fp=%g, want %b fp=%g", j,
                 {ack, busy, done, aborted, filt_reset}, fp_rst, e[5:1],
                 e[0] ? FP_SNAP_V : FP_HOLD_V);
      end
      if (j == 4) begin
        reset = 1'b1;
        exp_done = 0;
        exp_abort = 0;
      end
      if (j == 5) reset = 1'b0;
      if (j == 6) req = 1'b0;
    end
    exp_done++;
  endtask

  task automatic test_stats();
`ifdef PWL_RST_SEQ_STATS_EN
    checks++;
    if (seq_count !== exp_done[15:0]) begin
      errors++;
      $display("FAIL seq_count: got %0d, want %0d", seq_count, exp_done);
    end
    checks++;
    if (abort_count !== exp_abort[15:0]) begin
      errors++;
      $display("FAIL abort_count: got %0d, want %0d", abort_count, exp_abort);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (seq_count !== 16'd0 || abort_count !== 16'd0) begin
      errors++;
      $display("FAIL stats_reset: got %0d/%0d, want 0/0", seq_count, abort_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_sequence(2, 3, 4, "seq_2_3_4");
    test_sequence(0, 0, 0, "seq_0_0_0");
    test_sequence(0, 5, 0, "seq_0_5_0");
    test_sequence(1, 0, 0, "seq_1_0_0");
    test_abort(4, 4, 4, 6, "abort_hold");
    test_sequence(1, 2, 1, "after_abort");
    test_abort(3, 0, 0, 1, "abort_snap");
    test_abort(0, 0, 3, 3, "abort_settle_last");
    test_abort_ignored();
    test_back_to_back();
    test_sequence(255, 0, 1, "seq_max");
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
